// File: rtl/pwm_capture_16bits.sv
// Capture/monitor for one complementary PWM pair: measures A period, A high time
// and both dead times once per A period, with sticky shoot-through and overflow flags.
module pwm_capture_16bits #(
  parameter int unsigned PWMCOUNT_WIDTH = 16,
  parameter int unsigned DTCOUNT_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture_onoff,
  input  logic                      clear,
  input  logic                      pwm_A_in,
  input  logic                      pwm_B_in,
  output logic [PWMCOUNT_WIDTH-1:0] period_out,
  output logic [PWMCOUNT_WIDTH-1:0] high_A_out,
  output logic [DTCOUNT_WIDTH-1:0]  dt_AB_out,
  output logic [DTCOUNT_WIDTH-1:0]  dt_BA_out,
  output logic                      valid,
  output logic                      overflow,
  output logic                      shoot_through
);

  localparam int unsigned PW = PWMCOUNT_WIDTH;
  localparam int unsigned DW = DTCOUNT_WIDTH;
  localparam logic [PW-1:0] PER_MAX = '1;
  localparam logic [DW-1:0] DT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_dly_q, b_dly_q;
  logic                   a_s, b_s, a_rise, a_fall, b_rise, b_fall;

  logic [PW-1:0] per_cnt_q, high_shadow_q, period_q, high_q;
  logic [DW-1:0] dtab_cnt_q, dtba_cnt_q, dtab_shadow_q, dtba_shadow_q;
  logic [DW-1:0] dtab_out_q, dtba_out_q;
  logic          dtab_run_q, dtba_run_q;
  logic          valid_q, overflow_q, shoot_q;

  logic [PW-1:0] per_inc_c;
  logic [DW-1:0] dtab_inc_c, dtba_inc_c, dtba_val_c;

  // Pin synchronizers plus one delay flop per pin for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_dly_q  <= 1'b0;
      b_dly_q  <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], pwm_A_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], pwm_B_in};
      a_dly_q  <= a_s;
      b_dly_q  <= b_s;
    end
  end

  assign a_s    = a_sync_q[SYNC_STAGES-1];
  assign b_s    = b_sync_q[SYNC_STAGES-1];
  assign a_rise = a_s & ~a_dly_q;
  assign a_fall = ~a_s & a_dly_q;
  assign b_rise = b_s & ~b_dly_q;
  assign b_fall = ~b_s & b_dly_q;

  // Saturating increments; nothing in this block ever wraps
  always_comb begin
    per_inc_c  = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PW'(1);
    dtab_inc_c = (dtab_cnt_q == DT_MAX) ? DT_MAX : dtab_cnt_q + DW'(1);
    dtba_inc_c = (dtba_cnt_q == DT_MAX) ? DT_MAX : dtba_cnt_q + DW'(1);
    dtba_val_c = dtba_run_q ? dtba_inc_c : dtba_shadow_q;
  end

  // Capture FSM, measurement counters, shadows and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      per_cnt_q     <= '0;
      high_shadow_q <= '0;
      dtab_cnt_q    <= '0;
      dtba_cnt_q    <= '0;
      dtab_shadow_q <= '0;
      dtba_shadow_q <= '0;
      dtab_run_q    <= 1'b0;
      dtba_run_q    <= 1'b0;
      period_q      <= '0;
      high_q        <= '0;
      dtab_out_q    <= '0;
      dtba_out_q    <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      shoot_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Sticky flags: a set in the same cycle as clear wins
      if (clear) begin
        overflow_q <= 1'b0;
        shoot_q    <= 1'b0;
      end
      if ((state_q != ST_IDLE) && a_s && b_s) shoot_q <= 1'b1;

      if (state_q != ST_IDLE) begin
        dtab_cnt_q <= a_fall ? '0 : dtab_inc_c;
        dtba_cnt_q <= b_fall ? '0 : dtba_inc_c;
        if (b_rise && dtab_run_q) begin
          dtab_shadow_q <= dtab_inc_c;
          dtab_run_q    <= 1'b0;
        end
        if (a_rise) dtab_run_q <= 1'b0;
        if (a_fall) dtab_run_q <= 1'b1;
        // A rise closes a B-fall window; an A rise without one keeps the old value
        if (a_rise && dtba_run_q) begin
          dtba_shadow_q <= dtba_inc_c;
          dtba_run_q    <= 1'b0;
        end
        if (b_fall) dtba_run_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (capture_onoff) state_q <= ST_ARM;
        end
        ST_ARM: begin
          if (a_rise) begin
            per_cnt_q <= '0;
            state_q   <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          per_cnt_q <= per_inc_c;
          if (a_fall) high_shadow_q <= per_inc_c;
          if (a_rise) begin
            period_q   <= per_inc_c;
            high_q     <= high_shadow_q;
            dtab_out_q <= dtab_shadow_q;
            dtba_out_q <= dtba_val_c;
            valid_q    <= 1'b1;
            per_cnt_q  <= '0;
          end else if (per_cnt_q == PER_MAX) begin
            overflow_q <= 1'b1;
            per_cnt_q  <= '0;
            state_q    <= ST_ARM;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Disabling drops any partial measurement; counters restart from zero
      if (!capture_onoff || (state_q == ST_IDLE)) begin
        per_cnt_q  <= '0;
        dtab_cnt_q <= '0;
        dtba_cnt_q <= '0;
        dtab_run_q <= 1'b0;
        dtba_run_q <= 1'b0;
      end
      if (!capture_onoff) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign period_out    = period_q;
  assign high_A_out    = high_q;
  assign dt_AB_out     = dtab_out_q;
  assign dt_BA_out     = dtba_out_q;
  assign valid         = valid_q;
  assign overflow      = overflow_q;
  assign shoot_through = shoot_q;

endmodule

// File: tb/tb_pwm_capture_16bits.sv
// Self-checking bench for pwm_capture_16bits: table vectors, random waveforms
// against an arithmetic model, and hand-written flag/overflow/reset/enable sequences.
module tb_pwm_capture_16bits;

  logic        clk = 1'b0;
  logic        reset, capture_onoff, clear, pwm_A_in, pwm_B_in;
  logic [15:0] period_out, high_A_out;
  logic [7:0]  dt_AB_out, dt_BA_out;
  logic        valid, overflow, shoot_through;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { int cyc; int per; int hi; int dab; int dba; } vrec_t;
  typedef struct { int n; int h; int dab; int dba; int eper; int ehi; int edab; int edba; } vec_t;

  vrec_t vq[$];
  int    rise_q[$];
  vrec_t mon_r;
  vec_t  vecs[5];

  pwm_capture_16bits dut (
    .clk          (clk),
    .reset        (reset),
    .capture_onoff(capture_onoff),
    .clear        (clear),
    .pwm_A_in     (pwm_A_in),
    .pwm_B_in     (pwm_B_in),
    .period_out   (period_out),
    .high_A_out   (high_A_out),
    .dt_AB_out    (dt_AB_out),
    .dt_BA_out    (dt_BA_out),
    .valid        (valid),
    .overflow     (overflow),
    .shoot_through(shoot_through)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid strobe with its cycle number
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.per = int'(period_out);
      mon_r.hi  = int'(high_A_out);
      mon_r.dab = int'(dt_AB_out);
      mon_r.dba = int'(dt_BA_out);
      vq.push_back(mon_r);
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ideal pair: A high for h of n cycles, B rises dab after A falls, falls dba before A rises
  task automatic wave(input int n, input int h, input int dab, input int dba,
                      input int start, input int len);
    for (int c = 0; c < len; c++) begin
      int ph;
      @(negedge clk);
      ph = (start + c) % n;
      pwm_A_in = (ph < h);
      pwm_B_in = (ph >= h + dab) && (ph < n - dba);
      if (ph == 0) rise_q.push_back(cyc);
    end
  endtask

  task automatic check_valids(input string nm, input int first_rise, input int nexp,
                              input int eper, input int ehi, input int edab, input int edba);
    chk({nm, " valid count"}, vq.size(), nexp);
    for (int i = 0; i < nexp && i < vq.size(); i++) begin
      chk({nm, " valid cycle"}, vq[i].cyc, rise_q[first_rise + i] + 3);
      chk({nm, " period"}, vq[i].per, eper);
      chk({nm, " high"}, vq[i].hi, ehi);
      chk({nm, " dt_AB"}, vq[i].dab, edab);
      chk({nm, " dt_BA"}, vq[i].dba, edba);
    end
  endtask

  task automatic run_vec(input string nm, input int n, input int h, input int dab, input int dba,
                         input int eper, input int ehi, input int edab, input int edba);
    capture_onoff = 1'b0;
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(3);
    capture_onoff = 1'b1;
    tick(4);
    vq.delete();
    rise_q.delete();
    wave(n, h, dab, dba, 0, n * 4);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(8);
    check_valids(nm, 1, 3, eper, ehi, edab, edba);
    chk({nm, " overflow"}, overflow, 0);
    chk({nm, " shoot_through"}, shoot_through, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " period_out"}, period_out, 0);
    chk({nm, " high_A_out"}, high_A_out, 0);
    chk({nm, " dt_AB_out"}, dt_AB_out, 0);
    chk({nm, " dt_BA_out"}, dt_BA_out, 0);
    chk({nm, " valid"}, valid, 0);
    chk({nm, " overflow"}, overflow, 0);
    chk({nm, " shoot_through"}, shoot_through, 0);
  endtask

  initial begin
    vecs[0] = '{100, 30,   5,   7, 100, 30,   5,   7};
    vecs[1] = '{400, 80, 300,   7, 400, 80, 255,   7};
    vecs[2] = '{200, 100,  1,   1, 200, 100,  1,   1};
    vecs[3] = '{400, 80,   3, 300, 400, 80,   3, 255};
    vecs[4] = '{16,  8,    2,   2,  16,  8,   2,   2};

    reset = 1'b1;
    capture_onoff = 1'b0;
    clear = 1'b0;
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(3);
    reset = 1'b1;
    tick(2);

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].n, vecs[i].h, vecs[i].dab, vecs[i].dba,
              vecs[i].eper, vecs[i].ehi, vecs[i].edab, vecs[i].edba);

    for (int r = 0; r < 6; r++) begin
      int n, h, dab, dba;
      n   = int'($urandom_range(20, 300));
      h   = int'($urandom_range(1, n - 3));
      dab = int'($urandom_range(1, n - h - 2));
      dba = int'($urandom_range(1, n - h - 1 - dab));
      run_vec($sformatf("rand%0d", r), n, h, dab, dba,
              sat(n, 65535), sat(h, 65535), sat(dab, 255), sat(dba, 255));
    end

    // Shoot-through: set, sticky, clear, and clear overlapping a new overlap
    wave(100, 30, 5, 7, 0, 150);
    chk("st before overlap", shoot_through, 0);
    @(negedge clk);
    pwm_A_in = 1'b1;
    pwm_B_in = 1'b1;
    tick(3);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(4);
    chk("st set", shoot_through, 1);
    tick(20);
    chk("st sticky", shoot_through, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("st cleared", shoot_through, 0);
    pwm_A_in = 1'b1;
    pwm_B_in = 1'b1;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("st set beats clear", shoot_through, 1);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("st cleared again", shoot_through, 0);

    // Overflow: one A pulse, then A held low until the period counter saturates
    capture_onoff = 1'b0;
    tick(3);
    capture_onoff = 1'b1;
    tick(4);
    vq.delete();
    rise_q.delete();
    wave(200, 30, 5, 7, 0, 30);
    @(negedge clk);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(65508);
    chk("ovf not yet", overflow, 0);
    tick(1);
    chk("ovf set", overflow, 1);
    chk("ovf no valid", vq.size(), 0);
    vq.delete();
    wave(200, 60, 5, 7, 0, 600);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(8);
    check_valids("ovf resume", 2, 2, 200, 60, 5, 7);
    chk("ovf sticky", overflow, 1);

    // Asynchronous reset in the middle of a measurement
    vq.delete();
    rise_q.delete();
    wave(100, 30, 5, 7, 0, 250);
    chk("pre-reset period", period_out, 100);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("async reset");
    tick(3);
    chk_all_zero("reset held");
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    reset = 1'b1;
    tick(2);
    run_vec("after reset", 100, 30, 5, 7, 100, 30, 5, 7);

    // Capture disabled mid-period, then re-enabled
    capture_onoff = 1'b0;
    tick(3);
    capture_onoff = 1'b1;
    tick(4);
    vq.delete();
    rise_q.delete();
    wave(200, 50, 4, 6, 0, 350);
    capture_onoff = 1'b0;
    wave(200, 50, 4, 6, 350, 100);
    chk("off valid count", vq.size(), 1);
    chk("off hold period", period_out, 200);
    chk("off hold high", high_A_out, 50);
    chk("off hold dt_AB", dt_AB_out, 4);
    chk("off hold dt_BA", dt_BA_out, 6);
    capture_onoff = 1'b1;
    wave(200, 50, 4, 6, 450, 400);
    pwm_A_in = 1'b0;
    pwm_B_in = 1'b0;
    tick(8);
    chk("reenable valid count", vq.size(), 2);
    if (vq.size() >= 2) begin
      chk("reenable valid cycle", vq[1].cyc, rise_q[4] + 3);
      chk("reenable period", vq[1].per, 200);
      chk("reenable high", vq[1].hi, 50);
      chk("reenable dt_AB", vq[1].dab, 4);
      chk("reenable dt_BA", vq[1].dba, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture_16bits.md
Name: pwm_capture_16bits

Overview:
Gate-signal capture and monitor for one complementary PWM channel pair (A/B), such as a pair produced by the carrier/compare/dead-time chain. It samples the A and B pins asynchronously to clk and measures the A period, the A high time, and both dead times. It flags shoot-through and counter overflow. Results are transferred to output registers once per A period with a valid strobe, for AXI readback and closed-loop duty checks.

Parameters:
PWMCOUNT_WIDTH, 16, width of period/high-time counters and outputs
DTCOUNT_WIDTH, 8, width of dead-time counters and outputs
SYNC_STAGES, 2, input synchronizer depth (legal: 2..4)

Ports:
clk  input  1  capture clock; the only clock
reset  input  1  asynchronous, active-low reset
capture_onoff  input  1  1 = capture enabled; 0 = IDLE
clear  input  1  synchronous clear of sticky flags
pwm_A_in  input  1  PWM pin A, asynchronous to clk
pwm_B_in  input  1  PWM pin B, asynchronous to clk
period_out  output  PWMCOUNT_WIDTH  A rise-to-rise period, clk cycles
high_A_out  output  PWMCOUNT_WIDTH  A high time, clk cycles
dt_AB_out  output  DTCOUNT_WIDTH  A fall to B rise, clk cycles
dt_BA_out  output  DTCOUNT_WIDTH  B fall to A rise, clk cycles
valid  output  1  one-cycle strobe; all four results updated
overflow  output  1  sticky: period counter saturated
shoot_through  output  1  sticky: A and B simultaneously high

Behaviour:
- Reset (async, reset=0): all outputs 0, all counters 0, FSM = IDLE. Release is taken on the next clk edge.
- Each input passes through a SYNC_STAGES flop chain. Edge detection compares the last sync stage against one delay flop: rise = s & ~s_d, fall = ~s & s_d.
- Latency: an input pin transition reaches the affected registered output after SYNC_STAGES+1 clk edges.
- FSM states:
  - IDLE: counters held at 0; outputs and flags hold their last values. capture_onoff=1 moves to ARM.
  - ARM: waits for A rise. On A rise: per_cnt <= 0, go to MEASURE, no valid.
  - MEASURE: per_cnt increments every cycle. On A rise: period_out <= per_cnt+1, high_A_out <= high_shadow, dt_AB_out <= dtab_shadow, dt_BA_out <= current dt_BA count+1 (saturating), valid=1 for one cycle, per_cnt <= 0.
  - capture_onoff=0 in any state goes to IDLE next cycle; a partial measurement is discarded with no valid.
- high_shadow <= per_cnt+1 on A fall in MEASURE. For an A waveform with period N and high time H, the bench reads exactly N and H.
- dt_AB counter: cleared on A fall, increments each cycle, saturates at 2^DTCOUNT_WIDTH-1. Latched into dtab_shadow as cnt+1 (saturating) on B rise.
- dt_BA counter: same rules, started by B fall and latched on A rise.
- A dead-time event with no preceding start edge in the current period leaves the shadow at its previous value.
- Overflow: when per_cnt reaches all-ones without an A rise, overflow <= 1, FSM goes to ARM, no valid. Measurement resumes from the next A rise.
- shoot_through <= 1 in any non-IDLE cycle where both synced A and B are 1.
- clear=1 zeros overflow and shoot_through. If a set condition occurs in the same cycle, set wins.
- Simultaneous events:
  - A rise and A fall cannot occur in the same cycle.
  - A rise and B rise in the same cycle: the A-rise transfer uses the shadow values from before that cycle.
  - B rise and B fall are handled independently of A events.
- All arithmetic is unsigned; no wrap-around anywhere; every counter saturates.

Test Plan:
1. A: period 100, high 30. B = complement of A with 5-cycle A-fall→B-rise and 7-cycle B-fall→A-rise gaps. Expect: first valid at the second A rise + 3 cycles; then period_out=100, high_A_out=30, dt_AB_out=5, dt_BA_out=7; valid exactly every 100 cycles.
2. Force A and B both high for 3 cycles mid-run → shoot_through=1 and it stays 1. Pulse clear=1 → 0 next cycle. Overlap clear with a new overlap → stays 1.
3. After one A rise, hold A low for 70000 cycles → overflow=1 when per_cnt reaches 65535, no valid. A period-200 waveform then resumes → valid with period_out=200 at the second rise.
4. dt_AB gap of 300 cycles → dt_AB_out=255 (saturated); other results remain correct.
5. Assert reset mid-MEASURE → all outputs 0 immediately, without waiting for a clk edge. Deassert and run scenario 1 → results match scenario 1.
6. Drop capture_onoff mid-period → no valid. Outputs hold last values. Re-enable → ARM, and the first valid arrives after two A rises.
